// File: rtl/cpu_ctrl_if.sv
// Signal bundle between cpu_ctrl_fsm (master) and its fetch/ALU/regfile/data-memory side (slave).
// Handshake: req stays high from its first cycle until ack is sampled high on a rising edge; the transfer
// completes on that edge (ack in the first req cycle = zero wait states); ack while req is low is ignored.
interface cpu_ctrl_if #(
  parameter int PC_W = 8
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [15:0]     imem_rdata;
  logic [1:0]      fmt_op;
  logic [15:0]     ir;
  logic [2:0]      alu_op;
  logic            alu_zero;
  logic            rf_we;
  logic [1:0]      rf_wsel;
  logic            dmem_req;
  logic            dmem_we;
  logic            dmem_ack;
  logic [PC_W-1:0] pc;
  logic            halted;
  logic [2:0]      state_dbg;

  modport master (
    output imem_req, imem_addr, fmt_op, ir, alu_op, rf_we, rf_wsel,
           dmem_req, dmem_we, pc, halted, state_dbg,
    input  imem_ack, imem_rdata, alu_zero, dmem_ack
  );

  modport slave (
    input  imem_req, imem_addr, fmt_op, ir, alu_op, rf_we, rf_wsel,
           dmem_req, dmem_we, pc, halted, state_dbg,
    output imem_ack, imem_rdata, alu_zero, dmem_ack
  );
endinterface

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle CPU control FSM: FETCH -> DECODE -> EXEC -> (MEM) -> (WB), all outputs registered.
// Optional macro HALT_INSN_EN: fmt 11 func 111 enters HALT (otherwise it is a NOP and halted is 0).
module cpu_ctrl_fsm #(
  parameter int PC_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  cpu_ctrl_if.master bus
);
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [15:0]     ir;
  logic            imem_req;
  logic            dmem_req;
  logic            dmem_we;
  logic            rf_we;
  logic [1:0]      rf_wsel;
  logic [1:0]      fmt;
  logic [2:0]      func;
  logic [PC_W-1:0] jmp_target;

  assign fmt  = ir[15:14];
  assign func = ir[13:11];

  // Branch/jump target is the low instruction byte, zero-extended for wide PCs.
  generate
    if (PC_W > 8) begin : g_target_ext
      assign jmp_target = {{(PC_W-8){1'b0}}, ir[7:0]};
    end else begin : g_target_trunc
      assign jmp_target = ir[PC_W-1:0];
    end
  endgenerate

`ifdef HALT_INSN_EN
  logic halted;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      pc       <= '0;
      ir       <= '0;
      imem_req <= 1'b0;
      dmem_req <= 1'b0;
      dmem_we  <= 1'b0;
      rf_we    <= 1'b0;
      rf_wsel  <= 2'd0;
`ifdef HALT_INSN_EN
      halted   <= 1'b0;
`endif
    end else begin
      rf_we <= 1'b0;
      case (state)
        S_FETCH: begin
          // After reset FETCH is entered with req low; raise it first so a stale ack is never taken.
          if (!imem_req) begin
            imem_req <= 1'b1;
          end else if (bus.imem_ack) begin
            imem_req <= 1'b0;
            ir       <= bus.imem_rdata;
            pc       <= pc + PC_W'(1);
            state    <= S_DECODE;
          end
        end
        S_DECODE: state <= S_EXEC;
        S_EXEC: begin
          if (fmt != 2'b11) begin
            state   <= S_WB;
            rf_we   <= 1'b1;
            rf_wsel <= 2'd0;
          end else begin
            case (func)
              3'b000: begin
                state   <= S_WB;
                rf_we   <= 1'b1;
                rf_wsel <= 2'd1;
              end
              3'b001, 3'b010: begin
                state    <= S_MEM;
                dmem_req <= 1'b1;
                dmem_we  <= (func == 3'b010);
              end
              3'b011: begin
                if (bus.alu_zero) pc <= jmp_target;
                state    <= S_FETCH;
                imem_req <= 1'b1;
              end
              3'b100: begin
                pc       <= jmp_target;
                state    <= S_FETCH;
                imem_req <= 1'b1;
              end
`ifdef HALT_INSN_EN
              3'b111: begin
                state  <= S_HALT;
                halted <= 1'b1;
              end
`endif
              default: begin
                state    <= S_FETCH;
                imem_req <= 1'b1;
              end
            endcase
          end
        end
        S_MEM: begin
          if (bus.dmem_ack) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            if (dmem_we) begin
              state    <= S_FETCH;
              imem_req <= 1'b1;
            end else begin
              state   <= S_WB;
              rf_we   <= 1'b1;
              rf_wsel <= 2'd2;
            end
          end
        end
        S_WB: begin
          state    <= S_FETCH;
          imem_req <= 1'b1;
        end
        S_HALT: state <= S_HALT;
        default: begin
          state    <= S_FETCH;
          imem_req <= 1'b1;
        end
      endcase
    end
  end

  assign bus.imem_req  = imem_req;
  assign bus.imem_addr = pc;
  assign bus.pc        = pc;
  assign bus.ir        = ir;
  assign bus.fmt_op    = fmt;
  assign bus.alu_op    = func;
  assign bus.rf_we     = rf_we;
  assign bus.rf_wsel   = rf_wsel;
  assign bus.dmem_req  = dmem_req;
  assign bus.dmem_we   = dmem_we;
  assign bus.state_dbg = state;
`ifdef HALT_INSN_EN
  assign bus.halted    = halted;
`else
  assign bus.halted    = 1'b0;
`endif
endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Self-checking bench for cpu_ctrl_fsm: instruction-level reference model, directed cases, random program.
module tb_cpu_ctrl_fsm;
  localparam int PC_W = 8;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  logic [15:0]     imem [256];
  logic [PC_W-1:0] m_pc;
  logic [15:0]     m_ir;

  cpu_ctrl_if #(.PC_W(PC_W)) bus ();
  cpu_ctrl_fsm #(.PC_W(PC_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver / scoreboard tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic noise();
    bus.imem_ack   = 1'($urandom);
    bus.dmem_ack   = 1'($urandom);
    bus.imem_rdata = 16'($urandom);
  endtask

  task automatic check_cycle(input logic e_ireq, input logic e_rfwe, input logic [1:0] e_wsel,
                             input logic e_dreq, input logic e_dwe, input logic e_halt);
    chk("imem_req",  32'(bus.imem_req),  32'(e_ireq));
    chk("imem_addr", 32'(bus.imem_addr), 32'(m_pc));
    chk("pc",        32'(bus.pc),        32'(m_pc));
    chk("ir",        32'(bus.ir),        32'(m_ir));
    chk("fmt_op",    32'(bus.fmt_op),    32'(m_ir[15:14]));
    chk("alu_op",    32'(bus.alu_op),    32'(m_ir[13:11]));
    chk("rf_we",     32'(bus.rf_we),     32'(e_rfwe));
    if (e_rfwe) chk("rf_wsel", 32'(bus.rf_wsel), 32'(e_wsel));
    chk("dmem_req",  32'(bus.dmem_req),  32'(e_dreq));
    chk("dmem_we",   32'(bus.dmem_we),   32'(e_dwe));
    chk("halted",    32'(bus.halted),    32'(e_halt));
  endtask

  // Reset for one edge; ack_in_reset models a late ack that must be discarded.
  task automatic do_reset(input logic ack_in_reset);
    rst            = 1'b1;
    bus.imem_ack   = ack_in_reset;
    bus.dmem_ack   = 1'b1;
    bus.imem_rdata = 16'hFFFF;
    step();
    m_pc = '0;
    m_ir = '0;
    check_cycle(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("rst_rf_wsel", 32'(bus.rf_wsel), 32'd0);
    rst          = 1'b0;
    bus.imem_ack = 1'b1;
    step();
  endtask

  // Reference model of one instruction, starting in its first fetch cycle.
  task automatic run_insn(input int fetch_wait, input int mem_wait, input int zero,
                          output int wb_cyc, output int dreq_cyc,
                          output logic [1:0] wsel, output logic halt_seen);
    int          w;
    int          cyc;
    logic [15:0] word;
    logic        z;
    logic        do_wb;
    logic        do_mem;
    logic        is_st;
    logic [1:0]  e_wsel;
    wb_cyc = 0; dreq_cyc = 0; wsel = 2'd0; halt_seen = 1'b0; cyc = 0;

    w = (fetch_wait < 0) ? int'($urandom_range(0, 3)) : fetch_wait;
    for (int i = 0; i < w; i++) begin
      noise();
      bus.imem_ack = 1'b0;
      cyc++;
      check_cycle(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      step();
    end
    word           = imem[m_pc];
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = word;
    bus.dmem_ack   = 1'($urandom);
    cyc++;
    check_cycle(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    step();
    m_ir = word;
    m_pc = m_pc + 8'd1;

    noise();
    cyc++;
    check_cycle(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    step();

    z = (zero < 0) ? 1'($urandom) : 1'(zero);
    noise();
    bus.alu_zero = z;
    cyc++;
    check_cycle(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    step();
    bus.alu_zero = 1'($urandom);

    do_wb = 1'b0; do_mem = 1'b0; is_st = 1'b0; e_wsel = 2'd0;
    if (word[15:14] != 2'b11) begin
      do_wb = 1'b1;
    end else begin
      case (word[13:11])
        3'd0: begin do_wb = 1'b1; e_wsel = 2'd1; end
        3'd1: begin do_mem = 1'b1; do_wb = 1'b1; e_wsel = 2'd2; end
        3'd2: begin do_mem = 1'b1; is_st = 1'b1; end
        3'd3: if (z) m_pc = word[7:0];
        3'd4: m_pc = word[7:0];
        3'd7: begin
`ifdef HALT_INSN_EN
          halt_seen = 1'b1;
`endif
        end
        default: ;
      endcase
    end

    if (do_mem) begin
      w = (mem_wait < 0) ? int'($urandom_range(0, 3)) : mem_wait;
      for (int i = 0; i < w; i++) begin
        noise();
        bus.dmem_ack = 1'b0;
        cyc++; dreq_cyc++;
        check_cycle(1'b0, 1'b0, 2'd0, 1'b1, is_st, 1'b0);
        step();
      end
      bus.imem_ack = 1'($urandom);
      bus.dmem_ack = 1'b1;
      cyc++; dreq_cyc++;
      check_cycle(1'b0, 1'b0, 2'd0, 1'b1, is_st, 1'b0);
      step();
    end

    if (do_wb) begin
      noise();
      cyc++;
      wb_cyc = cyc;
      wsel   = e_wsel;
      check_cycle(1'b0, 1'b1, e_wsel, 1'b0, 1'b0, 1'b0);
      step();
    end

    if (halt_seen) begin
      for (int i = 0; i < 3; i++) begin
        noise();
        check_cycle(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        step();
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int         wb_cyc;
    int         dreq_cyc;
    logic [1:0] wsel;
    logic       hs;
    logic [15:0] w;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0; bus.alu_zero = 1'b0; bus.imem_rdata = '0;
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
    step();

    // Minimum ALU instruction with imem_ack effectively tied high.
    do_reset(1'b1);
    chk("alu_c1_imem_req", 32'(bus.imem_req), 32'd1);
    run_insn(0, 0, -1, wb_cyc, dreq_cyc, wsel, hs);
    chk("alu_wb_cycle", 32'(wb_cyc), 32'd4);
    chk("alu_next_addr", 32'(bus.imem_addr), 32'd1);
    chk("alu_model_pc", 32'(m_pc), 32'd1);

    // LDI
    imem[0] = 16'hC02A;
    do_reset(1'b0);
    run_insn(-1, -1, -1, wb_cyc, dreq_cyc, wsel, hs);
    chk("ldi_wsel", 32'(wsel), 32'd1);
    chk("ldi_pc", 32'(bus.pc), 32'd1);

    // LD with three wait states
    imem[0] = 16'hC810;
    do_reset(1'b0);
    run_insn(1, 3, -1, wb_cyc, dreq_cyc, wsel, hs);
    chk("ld_dreq_cycles", 32'(dreq_cyc), 32'd4);
    chk("ld_wsel", 32'(wsel), 32'd2);

    // BEQZ taken / not taken
    imem[0] = 16'hD840;
    do_reset(1'b0);
    run_insn(0, 0, 1, wb_cyc, dreq_cyc, wsel, hs);
    chk("beqz_taken_addr", 32'(bus.imem_addr), 32'h40);
    do_reset(1'b1);
    run_insn(0, 0, 0, wb_cyc, dreq_cyc, wsel, hs);
    chk("beqz_not_taken_addr", 32'(bus.imem_addr), 32'h01);

    // JMP to 0xFF then fetch there: pc wraps to 0
    imem[0] = 16'hE0FF;
    imem[255] = 16'h0000;
    do_reset(1'b0);
    run_insn(0, 0, -1, wb_cyc, dreq_cyc, wsel, hs);
    chk("jmp_addr", 32'(bus.imem_addr), 32'hFF);
    run_insn(2, 0, -1, wb_cyc, dreq_cyc, wsel, hs);
    chk("wrap_pc", 32'(bus.pc), 32'h00);

    // Reset in the middle of a fetch wait, with a late ack in the reset cycle
    imem[0] = 16'hC02A;
    imem[1] = 16'h1234;
    do_reset(1'b0);
    run_insn(0, 0, -1, wb_cyc, dreq_cyc, wsel, hs);
    for (int i = 0; i < 2; i++) begin
      noise();
      bus.imem_ack = 1'b0;
      check_cycle(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      step();
    end
    do_reset(1'b1);
    chk("rst_restart_req", 32'(bus.imem_req), 32'd1);
    chk("rst_restart_addr", 32'(bus.imem_addr), 32'd0);
    run_insn(-1, -1, -1, wb_cyc, dreq_cyc, wsel, hs);

    // fmt 11 func 111
    imem[0] = 16'hF800;
    imem[1] = 16'h0000;
    do_reset(1'b0);
    run_insn(0, 0, -1, wb_cyc, dreq_cyc, wsel, hs);
`ifdef HALT_INSN_EN
    chk("halt_model", 32'(hs), 32'd1);
    chk("halt_flag", 32'(bus.halted), 32'd1);
    chk("halt_no_fetch", 32'(bus.imem_req), 32'd0);
`else
    chk("nop_next_addr", 32'(bus.imem_addr), 32'd1);
    chk("nop_fetching", 32'(bus.imem_req), 32'd1);
`endif

    // Random program with random wait states and occasional resets
    for (int i = 0; i < 256; i++) begin
      w = 16'($urandom);
      if (w[15:14] == 2'b11 && w[13:11] == 3'b111) w[13:11] = 3'b000;
      imem[i] = w;
    end
    do_reset(1'b1);
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 49) == 0) do_reset(1'($urandom));
      run_insn(-1, -1, -1, wb_cyc, dreq_cyc, wsel, hs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/cpu_ctrl_fsm.md
CPU_CTRL_FSM -- requirements
Module: cpu_ctrl_fsm

Interface
REQ-001 SHALL have parameter PC_W, default 8, program counter width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port imem_req  output  1  instruction fetch request.
REQ-005 SHALL have port imem_addr  output  PC_W  fetch address, equals pc.
REQ-006 SHALL have port imem_ack  input  1  fetch data valid this cycle.
REQ-007 SHALL have port imem_rdata  input  16  fetched instruction word.
REQ-008 SHALL have port fmt_op  output  2  field-splitter format select, equals ir[15:14].
REQ-009 SHALL have port ir  output  16  latched instruction, drives field-splitter x input.
REQ-010 SHALL have port alu_op  output  3  ALU function, equals ir[13:11].
REQ-011 SHALL have port alu_zero  input  1  ALU result-is-zero flag.
REQ-012 SHALL have port rf_we  output  1  register-file write strobe, one cycle wide.
REQ-013 SHALL have port rf_wsel  output  2  writeback source: 0 ALU, 1 imm8, 2 data memory.
REQ-014 SHALL have port dmem_req, dmem_we  output  1 each  data access request, write enable.
REQ-015 SHALL have port dmem_ack  input  1  data access complete.
REQ-016 SHALL have port pc  output  PC_W  program counter.
REQ-017 SHALL have port halted  output  1  core stopped.

Function
REQ-018 SHALL implement states FETCH, DECODE, EXEC, MEM, WB, HALT; one state per cycle unless waiting on ack.
REQ-019 FETCH: imem_req=1 held until imem_ack sampled high; on that edge ir<=imem_rdata, pc<=pc+1 (wraps all-ones->0), go DECODE.
REQ-020 DECODE: one cycle, no strobes; fmt_op/alu_op stable from ir for splitter and register read; go EXEC.
REQ-021 EXEC, fmt 00/01/10: ALU op; go WB with rf_wsel=0.
REQ-022 EXEC, fmt 11: func 000 LDI -> WB rf_wsel=1; 001 LD, 010 ST -> MEM; 011 BEQZ: if alu_zero then pc<=ir[PC_W-1:0] (zero-extended if PC_W>8), go FETCH; 100 JMP: pc<=ir[PC_W-1:0], go FETCH; others NOP -> FETCH.
REQ-023 MEM: dmem_req=1, dmem_we=1 for ST only, held until dmem_ack; LD -> WB rf_wsel=2, ST -> FETCH.
REQ-024 WB: rf_we=1 for exactly one cycle, go FETCH.
REQ-025 imem_ack or dmem_ack while the matching req is low SHALL be ignored.
REQ-026 ack asserted in the first cycle of req SHALL complete that cycle (zero wait states); minimum ALU instruction = 4 cycles.
REQ-027 rf_we, dmem_req, imem_req SHALL never be high in the same cycle.
REQ-028 HALT: all strobes low, halted=1, pc and ir frozen; exit only by rst.

Reset
REQ-029 rst high at any edge, including mid-handshake, SHALL force state FETCH, pc=0, ir=0, all strobes 0, halted=0, rf_wsel=0, on that edge.
REQ-030 An ack arriving in the reset cycle SHALL be discarded; fetch restarts at address 0 the cycle after rst deasserts.

Configuration
REQ-031 With HALT_INSN_EN defined, fmt 11 func 111 SHALL enter HALT from EXEC; without it func 111 SHALL be a NOP and state HALT SHALL be unreachable (halted tied 0).

Verification
REQ-032 Reset, imem_ack tied high, mem word 0 = 16'h0000 -> imem_req cycle 1, rf_we high in cycle 4, pc=1, next fetch addr 1.
REQ-033 LDI 16'hC0_2A at pc 0 -> rf_we=1 with rf_wsel=1 in WB, pc=1.
REQ-034 LD 16'hC8_10 with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, then rf_we with rf_wsel=2.
REQ-035 BEQZ 16'hD8_40 with alu_zero=1 -> next imem_addr=8'h40; with alu_zero=0 -> next imem_addr=pc+1; JMP from pc 8'hFF path -> wrap check pc 8'hFF fetch gives pc=0.
REQ-036 rst asserted during FETCH wait (imem_ack low) -> next edge pc=0, imem_req restarts, late ack discarded.
REQ-037 HALT_INSN_EN defined, word 16'hF800 -> halted=1, no further imem_req; undefined -> treated as NOP, fetch continues.
